// File: rtl/ctr_stream_ctrl.sv
// ctr_stream_ctrl: sequences a message through an AES-CTR core one 128-bit block at a time.
//
// Ports
//   clk, reset_n        : clock (rising edge) and asynchronous active-low reset
//   start, msg_len, iv  : message request; msg_len (bytes) and iv are latched when start is
//                         accepted in IDLE
//   in_valid/in_ready   : input block handshake; in_data carries the block (a partial final
//                         block sits in the low bytes)
//   out_valid/out_ready : result handshake; out_data is registered, out_last marks the final block
//   busy, done          : busy is high outside IDLE; done pulses once at message end
//   ctr_init/next/finalize : one-cycle commands to the CTR core
//   ctr_init_counter    : latched iv presented to the core
//   ctr_block_i         : registered input block presented to the core
//   ctr_len_i           : valid bit count of the block being processed
//   ctr_ready           : one-cycle completion pulse from the core
//   ctr_block_o         : core result, only meaningful while ctr_ready is high
//
// LEN_W must be at least 5 so the 16-byte block size is representable in rem_q.
module ctr_stream_ctrl #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [127:0]     iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             ctr_init,
  output logic             ctr_next,
  output logic             ctr_finalize,
  output logic [127:0]     ctr_init_counter,
  output logic [127:0]     ctr_block_i,
  output logic [7:0]       ctr_len_i,
  input  logic             ctr_ready,
  input  logic [127:0]     ctr_block_o
);

  localparam logic [LEN_W-1:0] BlkBytes = LEN_W'(16);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StWaitInit,
    StGet,
    StIssue,
    StWaitBlk,
    StPut,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0] rem_q;     // bytes still to be processed
  logic [127:0]     iv_q;
  logic [127:0]     blk_q;
  logic [127:0]     out_q;
  logic [7:0]       len_q;

  logic             rem_zero;
  logic             rem_gt_blk;
  logic [7:0]       len_calc;
  logic [LEN_W-1:0] rem_dec;
  logic [127:0]     keep_mask;

  assign rem_zero   = (rem_q == '0);
  assign rem_gt_blk = (rem_q > BlkBytes);

  always_comb begin
    // 8*rem only matters below 16 bytes, so the low nibble is enough.
    len_calc  = (rem_q >= BlkBytes) ? 8'd128 : {1'b0, rem_q[3:0], 3'b000};
    rem_dec   = rem_gt_blk ? (rem_q - BlkBytes) : '0;
    // Non-final blocks always carry len_q == 128, so the mask only bites on a short final block.
    keep_mask = (len_q == 8'd128) ? '1 : ((128'd1 << len_q) - 128'd1);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start) state_d = StInit;
      StInit:     state_d = StWaitInit;
      StWaitInit: if (ctr_ready) state_d = rem_zero ? StDone : StGet;
      StGet:      if (in_valid) state_d = StIssue;
      StIssue:    state_d = StWaitBlk;
      StWaitBlk:  if (ctr_ready) state_d = StPut;
      StPut:      if (out_ready) state_d = rem_zero ? StDone : StGet;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    done         = 1'b0;
    ctr_init     = 1'b0;
    ctr_next     = 1'b0;
    ctr_finalize = 1'b0;
    busy         = (state_q != StIdle);
    unique case (state_q)
      StInit:  ctr_init = 1'b1;
      StGet:   in_ready = 1'b1;
      StIssue: begin
        ctr_next     = rem_gt_blk;
        ctr_finalize = !rem_gt_blk;
      end
      StPut: begin
        out_valid = 1'b1;
        out_last  = rem_zero;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      iv_q  <= '0;
      blk_q <= '0;
      out_q <= '0;
      len_q <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        rem_q <= msg_len;
        iv_q  <= iv;
      end
      // len_q is fixed here so it stays stable through ISSUE and WAIT_BLK.
      if (state_q == StGet && in_valid) begin
        blk_q <= in_data;
        len_q <= len_calc;
      end
      if (state_q == StWaitBlk && ctr_ready) begin
        out_q <= ctr_block_o & keep_mask;
        rem_q <= rem_dec;
      end
    end
  end

  assign out_data         = out_q;
  assign ctr_init_counter = iv_q;
  assign ctr_block_i      = blk_q;
  assign ctr_len_i        = len_q;

endmodule

// File: tb/tb_ctr_stream_ctrl.sv
module tb_ctr_stream_ctrl;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic [127:0]     iv;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             ctr_init;
  logic             ctr_next;
  logic             ctr_finalize;
  logic [127:0]     ctr_init_counter;
  logic [127:0]     ctr_block_i;
  logic [7:0]       ctr_len_i;
  logic             ctr_ready;
  logic [127:0]     ctr_block_o;

  ctr_stream_ctrl #(.LEN_W(LEN_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .msg_len          (msg_len),
    .iv               (iv),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy),
    .done             (done),
    .ctr_init         (ctr_init),
    .ctr_next         (ctr_next),
    .ctr_finalize     (ctr_finalize),
    .ctr_init_counter (ctr_init_counter),
    .ctr_block_i      (ctr_block_i),
    .ctr_len_i        (ctr_len_i),
    .ctr_ready        (ctr_ready),
    .ctr_block_o      (ctr_block_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } out_exp_t;

  typedef struct {
    logic         fin;
    logic [7:0]   len;
    logic [127:0] blk;
  } cmd_exp_t;

  out_exp_t out_q[$];
  cmd_exp_t cmd_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned core_lat = 1;
  logic [127:0] cur_iv = '0;
  int unsigned init_cnt, next_cnt, fin_cnt, done_cnt, out_cnt, inrdy_cnt, outv_cnt;
  logic [7:0] fin_len;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] ks(input logic [127:0] c, input int unsigned idx);
    return (c + {96'd0, idx}) ^ {4{32'hC3A5_5A3C}};
  endfunction

  function automatic logic [127:0] byte_mask(input int unsigned nbytes);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 128; i++) if (i < int'(nbytes * 8)) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_in_ready"},  in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_cmds"},      {ctr_init, ctr_next, ctr_finalize}, 0);
    check({tag, "_ctr_ctr"},   ctr_init_counter, 0);
    check({tag, "_ctr_blk"},   ctr_block_i, 0);
    check({tag, "_ctr_len"},   ctr_len_i, 0);
  endtask

  // CTR core model: checks each command against the scoreboard and answers after core_lat.
  initial begin : core_model
    int unsigned idx;
    logic [127:0] ctr;
    logic [127:0] resp;
    cmd_exp_t e;
    idx = 0;
    ctr = '0;
    ctr_ready = 1'b0;
    ctr_block_o = {4{32'hDEAD_BEEF}};
    forever begin
      @(negedge clk);
      if (reset_n && (ctr_init || ctr_next || ctr_finalize)) begin
        if (ctr_init) begin
          init_cnt++;
          idx  = 0;
          ctr  = ctr_init_counter;
          resp = {4{32'h0BAD_F00D}};
          check("ctr_init_counter", ctr_init_counter, cur_iv);
        end else begin
          if (ctr_next) next_cnt++;
          else begin
            fin_cnt++;
            fin_len = ctr_len_i;
          end
          resp = ctr_block_i ^ ks(ctr, idx);
          idx++;
          if (cmd_q.size() == 0) begin
            check("cmd_unexpected", {ctr_next, ctr_finalize}, 0);
          end else begin
            e = cmd_q.pop_front();
            check("cmd_is_finalize", ctr_finalize, e.fin);
            check("ctr_len_i", ctr_len_i, e.len);
            check("ctr_block_i", ctr_block_i, e.blk);
          end
        end
        repeat (core_lat) @(posedge clk);
        #1;
        ctr_ready   = 1'b1;
        ctr_block_o = resp;
        @(posedge clk);
        #1;
        ctr_ready   = 1'b0;
        ctr_block_o = {4{32'hDEAD_BEEF}};
      end
    end
  end

  // Command hygiene every cycle.
  initial begin : cmd_monitor
    forever begin
      @(negedge clk);
      check("cmd_onehot0", ($countones({ctr_init, ctr_next, ctr_finalize}) <= 1), 1);
      check("cmd_only_busy", (ctr_init | ctr_next | ctr_finalize) & ~busy, 0);
    end
  end

  // Output scoreboard monitor.
  initial begin : out_monitor
    out_exp_t e;
    forever begin
      @(negedge clk);
      if (in_ready) inrdy_cnt++;
      if (out_valid) outv_cnt++;
      if (done) done_cnt++;
      if (out_valid && in_ready) check("in_out_overlap", 1, 0);
      if (out_valid && out_ready) begin
        out_cnt++;
        if (out_q.size() == 0) begin
          check("out_unexpected", out_valid, 0);
        end else begin
          e = out_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
        end
      end
    end
  end

  task automatic clear_counts();
    init_cnt = 0; next_cnt = 0; fin_cnt = 0; done_cnt = 0;
    out_cnt = 0; inrdy_cnt = 0; outv_cnt = 0; fin_len = '0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle_timeout"}, (i < 60000), 1);
  endtask

  // Push expectations for one block, then hand it over.
  task automatic feed_block(input logic [127:0] d, input int unsigned rem, input int unsigned b,
                            input logic [127:0] ivv);
    cmd_exp_t c;
    out_exp_t o;
    int unsigned nb;
    int i;
    nb     = (rem >= 16) ? 16 : rem;
    c.fin  = (rem <= 16);
    c.len  = 8'(nb * 8);
    c.blk  = d;
    o.data = (d ^ ks(ivv, b)) & byte_mask(nb);
    o.last = (rem <= 16);
    cmd_q.push_back(c);
    out_q.push_back(o);
    in_valid = 1'b1;
    in_data  = d;
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("in_ready_timeout", (i < 1000), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic start_msg(input int unsigned len, input logic [127:0] ivv);
    cur_iv = ivv;
    @(posedge clk);
    #1;
    start   = 1'b1;
    msg_len = LEN_W'(len);
    iv      = ivv;
    @(posedge clk);
    #1;
    start   = 1'b0;
    iv      = '0;
  endtask

  task automatic send_msg(input int unsigned len, input logic [127:0] ivv,
                          input int unsigned exp_next, input int unsigned exp_fin,
                          input logic [7:0] exp_flen, input string tag);
    int unsigned rem;
    int unsigned nblk;
    wait_idle({tag, "_pre"});
    clear_counts();
    start_msg(len, ivv);
    rem  = len;
    nblk = (len + 15) / 16;
    for (int unsigned b = 0; rem > 0; b++) begin
      feed_block({4{b ^ 32'h1357_9BDF ^ len}} ^ ivv, rem, b, ivv);
      rem = (rem > 16) ? rem - 16 : 0;
    end
    wait_idle(tag);
    check({tag, "_init_cnt"}, init_cnt, 1);
    check({tag, "_next_cnt"}, next_cnt, exp_next);
    check({tag, "_fin_cnt"},  fin_cnt, exp_fin);
    check({tag, "_fin_len"},  fin_len, exp_flen);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_out_cnt"},  out_cnt, nblk);
    check({tag, "_out_left"}, out_q.size(), 0);
    check({tag, "_cmd_left"}, cmd_q.size(), 0);
  endtask

  task automatic stall_put();
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("stall_wait_valid", (i < 500), 1);
    repeat (10) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      if (out_q.size() > 0) begin
        check("stall_out_data", out_data, out_q[0].data);
        check("stall_out_last", out_last, out_q[0].last);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset_n   = 1'b0;
    start     = 1'b0;
    msg_len   = '0;
    iv        = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Stray core completion while idle must not wake the controller.
    ctr_ready = 1'b1;
    @(posedge clk);
    #1;
    ctr_ready = 1'b0;
    @(negedge clk);
    check("stray_ready_busy", busy, 0);

    // Empty message: init only, then done.
    send_msg(0, 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 0, 0, 8'd0, "len0");
    check("len0_in_ready", inrdy_cnt, 0);
    check("len0_out_valid", outv_cnt, 0);

    core_lat = 1;
    send_msg(32, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF0, 1, 1, 8'd128, "len32");
    core_lat = 3;
    send_msg(20, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1, 1, 8'd32, "len20");
    core_lat = 2;
    send_msg(5, 128'hA5A5_A5A5_0000_0000_5A5A_5A5A_FFFF_0000, 0, 1, 8'd40, "len5");
    send_msg(17, 128'h0, 1, 1, 8'd8, "len17");

    // Downstream back-pressure on the first result.
    core_lat  = 1;
    out_ready = 1'b0;
    fork
      send_msg(32, 128'hCAFE_BABE_0000_1111_2222_3333_4444_5555, 1, 1, 8'd128, "stall");
      stall_put();
    join

    // Start and reset while waiting on the core.
    wait_idle("rst_pre");
    clear_counts();
    core_lat = 6;
    start_msg(32, 128'h7777_6666_5555_4444_3333_2222_1111_0000);
    feed_block({4{32'h0F0F_F0F0}}, 32, 0, 128'h7777_6666_5555_4444_3333_2222_1111_0000);
    @(posedge clk);
    #1;
    start   = 1'b1;
    msg_len = LEN_W'(16);
    @(posedge clk);
    #1;
    start   = 1'b0;
    check("wblk_busy", busy, 1);
    check("wblk_start_ignored", init_cnt, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_q.delete();
    cmd_q.delete();
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle", busy, 0);
    check("midrst_no_out", out_cnt, 0);

    core_lat = 1;
    send_msg(16, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 1, 8'd128, "afresh16");

    send_msg(32'hFFFF, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00, 4095, 1, 8'd120, "lenmax");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctr_stream_ctrl.md
CTR_STREAM_CTRL -- requirements
Module: ctr_stream_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning the width of the message-length field in bytes.
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, begin message; sampled only in IDLE.
REQ-005 SHALL have port msg_len, input, LEN_W, message length in bytes; latched on accepted start.
REQ-006 SHALL have port iv, input, 128, initial counter block; latched on accepted start.
REQ-007 SHALL have port in_valid, input, 1, plaintext/ciphertext block valid.
REQ-008 SHALL have port in_ready, output, 1, block accepted when in_valid and in_ready are both 1.
REQ-009 SHALL have port in_data, input, 128, input block; partial last block in bits [8*rem-1:0].
REQ-010 SHALL have port out_valid, output, 1, result block valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port out_data, output, 128, result block, registered.
REQ-013 SHALL have port out_last, output, 1, qualifies the final block of a message.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at message end.
REQ-016 SHALL have ports ctr_init, ctr_next, ctr_finalize, output, 1 each, single-cycle commands to the CTR core.
REQ-017 SHALL have port ctr_init_counter, output, 128, latched iv.
REQ-018 SHALL have port ctr_block_i, output, 128, registered block to CTR core.
REQ-019 SHALL have port ctr_len_i, output, 8, valid bit count of final block.
REQ-020 SHALL have port ctr_ready, input, 1, one-cycle completion pulse from CTR core.
REQ-021 SHALL have port ctr_block_o, input, 128, CTR core result; valid only while ctr_ready is 1.

Function
REQ-022 SHALL implement states IDLE, INIT, WAIT_INIT, GET, ISSUE, WAIT_BLK, PUT, DONE.
REQ-023 IDLE: start=1 -> latch msg_len into rem_reg (LEN_W) and iv; go to INIT.
REQ-024 INIT: ctr_init=1 for exactly one cycle; go to WAIT_INIT.
REQ-025 WAIT_INIT: on ctr_ready, go to DONE if rem_reg==0, else to GET.
REQ-026 GET: in_ready=1; on handshake, register in_data into ctr_block_i; go to ISSUE.
REQ-027 ISSUE: one-cycle ctr_next if rem_reg>16, else one-cycle ctr_finalize; go to WAIT_BLK.
REQ-028 ctr_len_i SHALL be 128 when rem_reg>=16, else 8*rem_reg; it holds stable from ISSUE through the WAIT_BLK capture.
REQ-029 WAIT_BLK: on ctr_ready, capture ctr_block_o into out_data and set rem_reg = rem_reg - min(16, rem_reg); go to PUT.
REQ-030 On the final block, out_data bits [127:ctr_len_i] SHALL be forced to 0.
REQ-031 PUT: out_valid=1; out_last=1 iff rem_reg==0; on out_ready go to DONE if rem_reg==0, else GET.
REQ-032 out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-033 DONE: done=1 for one cycle; go to IDLE.
REQ-034 ctr_ready outside WAIT_INIT/WAIT_BLK SHALL be ignored; start while busy SHALL be ignored.
REQ-035 At most one of ctr_init, ctr_next, ctr_finalize SHALL be 1 in any cycle, and only in INIT/ISSUE.
REQ-036 ctr_block_i SHALL hold from GET latch until the WAIT_BLK capture.

Reset
REQ-037 reset_n=0 SHALL immediately force IDLE; all outputs, rem_reg, and data registers go to 0.
REQ-038 Reset mid-message SHALL discard the message; no done pulse; the next start begins afresh with ctr_init.

Verification
REQ-039 msg_len=0: start -> one ctr_init, ctr_ready -> done pulse; in_ready and out_valid never 1.
REQ-040 msg_len=32: block 1 uses ctr_next; block 2 uses ctr_finalize with ctr_len_i=128; out_last on block 2 only; out_data = in_data ^ keystream.
REQ-041 msg_len=20: block 2 uses ctr_finalize with ctr_len_i=32; out_data[127:32]=0.
REQ-042 out_ready=0 for 10 cycles in PUT: out_data constant; in_ready stays 0; resumes on out_ready=1.
REQ-043 start pulsed during WAIT_BLK is ignored; reset_n=0 in WAIT_BLK -> busy=0, all outputs 0, next start issues ctr_init.
REQ-044 msg_len=16'hFFFF: 4095 ctr_next commands, then one ctr_finalize with ctr_len_i=120; done pulse follows.
